// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encoding,
// default operand width and the bit-counter width helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_add_bit.sv
// One-bit full adder; shared by the serial adder and the future serial
// subtractor datapath.
module full_add_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands shift out LSB-first through one full
// adder and a registered carry; {carry,sum} is published with a done pulse.
//
// Handshake: start is accepted on a rising edge only while ready=1; the
// result is valid in the single cycle where done=1 and holds until the next
// completion or reset.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_cout;

    full_add_bit u_fa (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .cin (c_q),
        .s   (fa_s),
        .cout(fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Result fills from the MSB so it is aligned after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                c_d   = fa_cout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=4 and WIDTH=8 against a plain a+b model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, ready4, done4, carry4;
    logic [3:0] a4, b4, sum4;
    logic [1:0] st4;
    logic       start8, ready8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic [1:0] st8;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .done(done4), .sum(sum4), .carry(carry4), .dbg_state(st4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .sum(sum8), .carry(carry8), .dbg_state(st8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready4();
        int n = 0;
        while (!ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready4) check("ready4_wait", ready4, 1);
    endtask

    // One operation on the 4-bit unit; n counts edges from the accepting edge.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit full);
        int n;
        logic [8:0] e;
        wait_ready4();
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        exp_q.push_back(9'(a) + 9'(b));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        if (full) check("ready_drop", ready4, 0);
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        check("done_seen", done4, 1);
        if (full) check("latency4", n, 5);
        check("result4", {carry4, sum4}, e);
        @(negedge clk);
        if (full) begin
            check("done_one_cycle", done4, 0);
            check("ready_back", ready4, 1);
            check("result_hold", {carry4, sum4}, e);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        logic [8:0] e;
        while (!ready8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        exp_q.push_back(9'(a) + 9'(b));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 1;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        check("done8_seen", done8, 1);
        check("latency8", n, 9);
        check("result8", {carry8, sum8}, e);
    endtask

    initial begin
        int pulses, viol, p1, p2;
        logic [4:0] r1, r2;
        logic [7:0] ab;

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready4, 1);
        check("rst_done", done4, 0);
        check("rst_sum", sum4, 0);
        check("rst_carry", carry4, 0);
        check("rst_state", st4, 0);
        check("rst_ready8", ready8, 1);
        rst = 1'b0;
        @(negedge clk);

        run4(4'd5, 4'd3, 1);
        run4(4'd15, 4'd1, 1);
        run4(4'd9, 4'd12, 1);
        run4(4'd0, 4'd0, 1);

        // start and operand changes outside IDLE must be ignored
        wait_ready4();
        a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
        @(negedge clk);
        pulses = 0;
        r1 = '0;
        for (int k = 0; k < 12; k++) begin
            a4 = 4'd15;
            b4 = 4'd15;
            start4 = !ready4;
            @(negedge clk);
            if (done4) begin
                pulses++;
                r1 = {carry4, sum4};
            end
        end
        start4 = 1'b0;
        check("ignore_pulses", pulses, 1);
        check("ignore_result", r1, 13);

        // reset in the second SHIFT cycle aborts the operation
        @(negedge clk);
        wait_ready4();
        a4 = 4'd10; b4 = 4'd10; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready4, 1);
        check("abort_sum", sum4, 0);
        check("abort_carry", carry4, 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (done4) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        run4(4'd2, 4'd2, 1);

        // start held high: back-to-back operations
        wait_ready4();
        a4 = 4'd1; b4 = 4'd2; start4 = 1'b1;
        pulses = 0; viol = 0; p1 = 0; p2 = 0; r1 = '0; r2 = '0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                a4 = 4'd3;
                b4 = 4'd4;
            end
            if (n == 7) start4 = 1'b0;
            if (done4) begin
                pulses++;
                if (pulses == 1) begin p1 = n; r1 = {carry4, sum4}; end
                if (pulses == 2) begin p2 = n; r2 = {carry4, sum4}; end
            end else if (pulses == 1 && {carry4, sum4} != 5'd3) begin
                viol++;
            end
        end
        start4 = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_gap", p2 - p1, 6);
        check("b2b_first", r1, 3);
        check("b2b_second", r2, 7);
        check("b2b_hold", viol, 0);

        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            run4(ab[7:4], ab[3:0], 0);
        end

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run4(4'($urandom), 4'($urandom), 1);
        end

        run8(8'd200, 8'd100);
        run8(8'd255, 8'd1);
        run8(8'd0, 8'd0);
        for (int i = 0; i < 20; i++) run8(8'($urandom), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
